// File: rtl/led_sched_pkg.sv
// Shared types and elaboration-time helpers for the LED blink scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic bit params_ok(input int clk_hz, input int tick_hz, input int n_req,
                                   input int cnt_w, input int on_t, input int off_t,
                                   input int gap_t);
    return (tick_hz > 0) && (clk_hz % tick_hz == 0) && (clk_hz / tick_hz >= 2) &&
           (n_req >= 2) && (n_req <= 8) && (cnt_w >= 1) &&
           (on_t >= 1) && (off_t >= 1) && (gap_t >= 1);
  endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Zero latency; the caller registers the result.
module led_rr_arbiter import led_sched_pkg::*; #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/led_blink_sched.sv
// Shares one LED between N_REQ requesters, playing each granted code as N blinks plus a gap.
// Grant is registered one edge after req is sampled in IDLE; losers simply wait while holding req.
module led_blink_sched import led_sched_pkg::*; #(
  parameter int CLK_HZ  = 27000000,
  parameter int TICK_HZ = 1000,
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 4,
  parameter int ON_T    = 200,
  parameter int OFF_T   = 200,
  parameter int GAP_T   = 1000,
  parameter bit LED_ON  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] count,
  output logic [N_REQ-1:0]       grant,
  output logic                   done,
  output logic                   busy,
  output logic                   led
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int PRE_W = clog2(DIV);
  localparam int TCK_W = clog2(max3(ON_T, OFF_T, GAP_T) + 1);
  localparam int PTR_W = clog2(N_REQ);

  if (!params_ok(CLK_HZ, TICK_HZ, N_REQ, CNT_W, ON_T, OFF_T, GAP_T)) begin : g_param_err
    $error("led_blink_sched: invalid parameter set");
  end

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   presc_q;
  logic [TCK_W-1:0]   tick_q, dur_last;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_d;
  logic               done_d, led_d, enter, tick_end, expire;
  logic [N_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [CNT_W-1:0]   cnt_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    assign cnt_arr[i] = count[i*CNT_W +: CNT_W];
  end

  led_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ptr_d    = ptr_q;
    grant_d  = grant;
    done_d   = 1'b0;
    enter    = 1'b0;
    dur_last = '0;
    case (state_q)
      ON:      dur_last = TCK_W'(ON_T - 1);
      OFF:     dur_last = TCK_W'(OFF_T - 1);
      GAP:     dur_last = TCK_W'(GAP_T - 1);
      default: dur_last = '0;
    endcase
    tick_end = (presc_q == PRE_W'(DIV - 1));
    expire   = tick_end && (tick_q == dur_last);

    case (state_q)
      IDLE: if (arb_vld) begin
        grant_d = arb_gnt;
        rem_d   = cnt_arr[arb_idx];
        ptr_d   = (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
        state_d = (cnt_arr[arb_idx] != '0) ? ON : GAP;
        enter   = 1'b1;
      end
      ON: if (expire) begin
        state_d = OFF;
        enter   = 1'b1;
      end
      OFF: if (expire) begin
        rem_d   = (rem_q != '0) ? rem_q - CNT_W'(1) : '0;
        state_d = (rem_d != '0) ? ON : GAP;
        enter   = 1'b1;
      end
      GAP: if (expire) begin
        state_d = IDLE;
        grant_d = '0;
        done_d  = 1'b1;
        enter   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    led_d = (state_d == ON) ? LED_ON : ~LED_ON;
  end

  // Prescaler and tick counter restart on every state entry so durations are exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= '0;
      rem_q   <= '0;
      ptr_q   <= '0;
      grant   <= '0;
      done    <= 1'b0;
      led     <= ~LED_ON;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      grant   <= grant_d;
      done    <= done_d;
      led     <= led_d;
      if (enter || state_q == IDLE) begin
        presc_q <= '0;
        tick_q  <= '0;
      end else if (tick_end) begin
        presc_q <= '0;
        tick_q  <= tick_q + TCK_W'(1);
      end else begin
        presc_q <= presc_q + PRE_W'(1);
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
